// File: rtl/alu_seq_pkg.sv
// Shared opcode, state, error-code and instruction-layout definitions for the ALU sequencer.
package alu_seq_pkg;

   localparam int DATA_W  = 8;
   localparam int REG_N   = 4;
   localparam int INSTR_W = 14;

   localparam int OPC_HI = 13;
   localparam int OPC_LO = 10;
   localparam int RD_HI  = 9;
   localparam int RD_LO  = 8;
   localparam int RA_HI  = 7;
   localparam int RA_LO  = 6;
   localparam int RB_HI  = 5;
   localparam int RB_LO  = 4;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_MUL   = 4'h2;
   localparam logic [3:0] OP_DIV   = 4'h3;
   localparam logic [3:0] OP_AND   = 4'h4;
   localparam logic [3:0] OP_OR    = 4'h5;
   localparam logic [3:0] OP_XOR   = 4'h6;
   localparam logic [3:0] OP_NOT   = 4'h7;
   localparam logic [3:0] OP_SHLB  = 4'h8;
   localparam logic [3:0] OP_SHRB  = 4'h9;
   localparam logic [3:0] OP_LOADI = 4'hF;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_DIV0    = 2'b10;
   localparam logic [1:0] ERR_NOUPD   = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RETIRE = 2'd2
   } state_t;

   // Field order mirrors the bit positions above; for LOADI, {ra, rb, rsvd} is imm8.
   typedef struct packed {
      logic [3:0] opc;
      logic [1:0] rd;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [3:0] rsvd;
   } instr_t;

   function automatic logic is_alu_op(input logic [3:0] opc);
      return opc <= OP_SHRB;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus ALU operand/result bus; master is the sequencer side.
interface alu_sequencer_if;
   import alu_seq_pkg::*;

   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;
   logic [DATA_W-1:0]  alu_a;
   logic [DATA_W-1:0]  alu_b;
   logic [3:0]         alu_sel;
   logic               alu_latch;
   logic [DATA_W-1:0]  alu_result;
   logic               alu_carry;
   logic               alu_update;

   modport master (
      input  instr_valid, instr, alu_result, alu_carry, alu_update,
      output instr_ready, alu_a, alu_b, alu_sel, alu_latch
   );

   modport slave (
      output instr_valid, instr, alu_result, alu_carry, alu_update,
      input  instr_ready, alu_a, alu_b, alu_sel, alu_latch
   );

endinterface

// File: rtl/seq_regfile.sv
// 4x8 register file: one synchronous write port, two combinational operand reads and a debug read.
// Reads return the value after any write completed at the same or an earlier edge.
module seq_regfile
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [1:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        ra_sel,
   input  logic [1:0]        rb_sel,
   input  logic [1:0]        dbg_sel,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [REG_N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_N; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign ra_data  = regs[ra_sel];
   assign rb_data  = regs[rb_sel];
   assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one instruction at a time onto the external ALU and writes results back to the regfile.
// ALU op: done at accept+SETTLE_CYCLES+1; LOADI/errors: done at accept+1; instr_ready only in IDLE (producer holds).
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   alu_sequencer_if.master   bus,
   input  logic [1:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic              carry_flag,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   instr_t            ins;
   logic [DATA_W-1:0] imm8;
   logic [DATA_W-1:0] ra_data;
   logic [DATA_W-1:0] rb_data;

   state_t            state;
   logic [3:0]        settle_cnt;
   logic [1:0]        rd_q;
   logic              ready_q;
   logic              latch_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [3:0]        sel_q;

   logic              accept;
   logic              capture;
   logic              rf_we;
   logic [1:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   assign ins     = bus.instr;
   assign imm8    = {ins.ra, ins.rb, ins.rsvd};
   assign accept  = bus.instr_valid & ready_q;
   assign capture = (state == ISSUE) && (settle_cnt == 4'd1);

   // LOADI writes at the accept edge; ALU results write at the edge closing the last ISSUE cycle.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = rd_q;
      rf_wdata = bus.alu_result;
      if (accept && ins.opc == OP_LOADI) begin
         rf_we    = 1'b1;
         rf_waddr = ins.rd;
         rf_wdata = imm8;
      end else if (capture && bus.alu_update) begin
         rf_we = 1'b1;
      end
   end

   seq_regfile u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .ra_sel   (ins.ra),
      .rb_sel   (ins.rb),
      .dbg_sel  (dbg_sel),
      .ra_data  (ra_data),
      .rb_data  (rb_data),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         settle_cnt <= '0;
         rd_q       <= '0;
         ready_q    <= 1'b1;
         latch_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         sel_q      <= '0;
         carry_flag <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ready_q <= 1'b0;
                  if (ins.opc == OP_LOADI) begin
                     state <= RETIRE;
                     done  <= 1'b1;
                  end else if (!is_alu_op(ins.opc)) begin
                     state    <= RETIRE;
                     done     <= 1'b1;
                     err      <= 1'b1;
                     err_code <= ERR_ILLEGAL;
                  end else if (ins.opc == OP_DIV && rb_data == '0) begin
                     state    <= RETIRE;
                     done     <= 1'b1;
                     err      <= 1'b1;
                     err_code <= ERR_DIV0;
                  end else begin
                     // Operands are frozen here, so rd aliasing ra/rb is harmless.
                     state      <= ISSUE;
                     latch_q    <= 1'b1;
                     a_q        <= ra_data;
                     b_q        <= rb_data;
                     sel_q      <= ins.opc;
                     rd_q       <= ins.rd;
                     settle_cnt <= SETTLE_INIT;
                  end
               end
            end
            ISSUE: begin
               if (capture) begin
                  state   <= RETIRE;
                  latch_q <= 1'b0;
                  done    <= 1'b1;
                  if (bus.alu_update) begin
                     carry_flag <= bus.alu_carry;
                  end else begin
                     err      <= 1'b1;
                     err_code <= ERR_NOUPD;
                  end
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            RETIRE: begin
               state    <= IDLE;
               ready_q  <= 1'b1;
               done     <= 1'b0;
               err      <= 1'b0;
               err_code <= ERR_NONE;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               latch_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.alu_latch   = latch_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
   assign bus.alu_sel     = sel_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control/datapath stage directly upstream and downstream of the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 4x8-bit register file.
- Drives the ALU operand, select and latch inputs, then writes the ALU result and carry back into the register file.
- Supports load-immediate and rejects illegal opcodes and divide-by-zero before issue.

Parameters:
- SETTLE_CYCLES, 1, number of cycles alu_latch is held high before the result is captured (range 1..15).

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  14  [13:10] opcode, [9:8] rd, [7:6] ra, [5:4] rb, [3:0] reserved (ignored); for LOADI, [7:0] is imm8.
- alu_a  out  8  ALU operand A.
- alu_b  out  8  ALU operand B.
- alu_sel  out  4  ALU selection code.
- alu_latch  out  1  ALU output enable.
- alu_result  in  8  ALU 8-bit output.
- alu_carry  in  1  ALU carry-out flag.
- alu_update  in  1  ALU update-register flag.
- dbg_sel  in  2  register-file read select.
- dbg_data  out  8  combinational read of register dbg_sel.
- carry_flag  out  1  last captured ALU carry.
- done  out  1  one-cycle pulse per retired instruction.
- err  out  1  one-cycle pulse, coincident with done, on failure.
- err_code  out  2  00 none, 01 illegal opcode, 10 divide-by-zero, 11 missing alu_update; valid when err=1, else 00.

Behaviour:
- Reset (synchronous, takes effect from any state, including mid-operation):
  - state=IDLE; R0..R3=0.
  - carry_flag=0, done=0, err=0, err_code=00.
  - alu_latch=0, alu_a=0, alu_b=0, alu_sel=0.
  - instr_ready=1 in the first cycle after reset.
- States: IDLE, ISSUE, RETIRE.
- instr_ready=1 only in IDLE. Accept = instr_valid & instr_ready at a rising edge (cycle N).
- Opcodes:
  - 0000..1001 are ALU ops, passed through as alu_sel.
  - 1111 is LOADI.
  - 1010..1110 are illegal.
- At accept:
  - ra and rb values are captured into operand registers (a read sees any write completed at the same or an earlier edge).
  - rd and opcode are also captured.
- LOADI: at the accept edge, R[rd] <= imm8 and state -> RETIRE. done=1 in N+1. carry_flag unchanged. No ALU activity.
- Illegal opcode: no register change; state -> RETIRE. In N+1: done=1, err=1, err_code=01.
- Opcode 0011 with R[rb]==0: same as illegal, but err_code=10. The ALU is never issued.
- Valid ALU op: state -> ISSUE for SETTLE_CYCLES cycles (N+1 .. N+SETTLE_CYCLES).
  - alu_latch=1; alu_a, alu_b and alu_sel are stable from registers.
  - Settle counter counts down to 1.
- Capture at the edge ending the last ISSUE cycle:
  - If alu_update=1: R[rd] <= alu_result and carry_flag <= alu_carry.
  - If alu_update=0: no write, and flag err_code=11.
  - Then state -> RETIRE.
- RETIRE (1 cycle): done=1 (err/err_code per result), alu_latch=0, instr_ready=0; next state IDLE.
- Latency:
  - SETTLE_CYCLES=1: accept N, latch N+1, write at end of N+1, done N+2, next accept possible at end of N+3.
  - LOADI or error: done N+1, next accept at end of N+2.
- alu_a, alu_b and alu_sel hold their last values when latch=0. ALU inputs are sampled only while alu_latch=1 (the ALU tri-states otherwise).
- rd may equal ra/rb: operands are already captured, so there is no hazard.
- instr_valid is ignored outside IDLE; no instruction is dropped while ready=0 (the producer holds it).
- Results wider than 8 bits are truncated by the ALU; only bit 8 reaches the carry.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_ADD..OP_SHRB, OP_LOADI.
  - state encoding IDLE/ISSUE/RETIRE.
  - err_code constants ERR_NONE/ERR_ILLEGAL/ERR_DIV0/ERR_NOUPD.
  - instruction field bit positions.
- One sub-module: seq_regfile (4x8 registers, one synchronous write port, two capture read ports plus the combinational debug port, synchronous reset).

Test Plan:
- Reset, LOADI R1=0x05, LOADI R2=0x03, ADD rd=R0, ra=R1, rb=R2 with a model ALU -> alu_latch high exactly 1 cycle, alu_sel=0000, alu_a=05, alu_b=03; R0=0x08, carry_flag=0, done at N+2.
- LOADI R1=0xFF, R2=0x01, ADD rd=R3 -> R3=0x00, carry_flag=1; then SUB rd=R1, ra=R1, rb=R1 -> R1=0x00.
- DIV with R2=0 -> no alu_latch pulse, done=1/err=1/err_code=10 at N+1, rd unchanged; opcode 1100 -> err_code=01.
- Model ALU forcing alu_update=0 during ISSUE -> err_code=11, rd unchanged, carry_flag unchanged.
- SETTLE_CYCLES=3, MUL 0x04*0x05 -> alu_latch high 3 consecutive cycles, R0=0x14; instr_valid held high throughout -> exactly one accept per instruction.
- Assert reset during ISSUE -> next cycle alu_latch=0, all registers 0, instr_ready=1, no done pulse.
